alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
// - Shares one combinational ALU (adder/logic unit + N/Z/C/V flag logic) between two requesters.
// - Round-robin arbitration; each request is a valid/ready command {op, a, b}.
// - Latches operands, drives the ALU for one cycle, then registers result and flags.
// - Returns result and flags on a valid/ready response channel tagged with the requester ID.
// PARAMETERS
// - N      8   operand/result width (>=2)
// - OPW    4   ALU control word width (ALU control bit 0 = subtract for flag logic)
// PORTS
// - clk          in   1    clock, rising edge
// - rst          in   1    synchronous reset, active-high
// - req0_valid   in   1    requester 0 command valid
// - req0_ready   out  1    requester 0 command accepted this cycle
// - req0_op      in   OPW  requester 0 ALU control word
// - req0_a       in   N    requester 0 operand A
// - req0_b       in   N    requester 0 operand B
// - req1_valid   in   1    requester 1 command valid
// - req1_ready   out  1    requester 1 command accepted this cycle
// - req1_op      in   OPW  requester 1 ALU control word
// - req1_a       in   N    requester 1 operand A
// - req1_b       in   N    requester 1 operand B
// - alu_ctrl_o   out  OPW  to ALU: control word
// - alu_a_o      out  N    to ALU: operand A
// - alu_b_o      out  N    to ALU: operand B
// - alu_res_i    in   N    from ALU: result
// - alu_flags_i  in   4    from ALU: {N,Z,C,V}
// - rsp_valid    out  1    response valid
// - rsp_ready    in   1    response consumer ready
// - rsp_id       out  1    requester ID of the response
// - rsp_res      out  N    registered result
// - rsp_flags    out  4    registered {N,Z,C,V}
// - sticky_v     out  2    per-requester sticky overflow (see CONFIGURATION)
// - sticky_clr   in   2    per-requester sticky overflow clear
// BEHAVIOUR
// - FSM states: IDLE -> EXEC -> RESP -> IDLE.
// - IDLE:
//   - Arbitrate among asserted reqX_valid.
//   - Grant goes to the only requester, or to the pointer's requester if both are asserted.
//   - Asserts reqX_ready (combinational) for the granted requester only.
//   - On handshake: latch op/a/b/id, flip pointer to the other ID, go to EXEC.
// - EXEC (exactly 1 cycle):
//   - alu_* outputs are driven from the latches.
//   - At the clock edge, capture alu_res_i/alu_flags_i into rsp_res/rsp_flags, then go to RESP.
// - RESP:
//   - rsp_valid=1; hold rsp_* stable until rsp_ready.
//   - On rsp_valid&&rsp_ready, go to IDLE.
//   - Both reqX_ready=0 in EXEC and RESP.
// - Latency:
//   - Accept edge to rsp_valid is 2 cycles.
//   - Minimum throughput is one command per 3 cycles (rsp_ready held high).
// - alu_* outputs:
//   - Hold the last latched values outside EXEC.
//   - Are 0 after reset until the first accept.
// - Reset values:
//   - req*_ready=0 during rst.
//   - rsp_valid=0, rsp_id=0, rsp_res=0, rsp_flags=0, sticky_v=0.
//   - alu_*=0; pointer=req0; state=IDLE.
// - Reset mid-operation (EXEC or RESP):
//   - The in-flight command is dropped with no response.
//   - IDLE is re-entered the cycle after rst deasserts.
// - Boundary cases:
//   - Both valid: the pointer decides; no requester starves (strict alternation under contention).
//   - Requester drops valid before its grant: no effect, no state change.
//   - Response stall: any number of stall cycles; the next command is not accepted while in RESP.
// - No arithmetic in this block; widths pass through unchanged.
// CONFIGURATION
// - Macro ALU_STICKY_OVF_EN.
// - Defined:
//   - sticky_v[id] sets when RESP is entered with flags V=1 for that id.
//   - sticky_clr[id] clears it; set wins over a clear in the same cycle.
// - Undefined: sticky_v is tied to 0, sticky_clr is ignored, and no sticky registers are built.
// STRUCTURE
// - Package alu_ctrl_pkg:
//   - typedef enum state_t {IDLE, EXEC, RESP}.
//   - Flag index constants FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
//   - typedef req_id_t (1 bit).
// - Sub-module rr_arbiter2:
//   - 2-way round-robin; inputs req[1:0] and advance; output gnt[1:0].
//   - Holds the priority pointer.
// TESTING
// - Single request: req0 op=ADD a=8'h70 b=8'h20, alu_res_i=8'h90, flags=4'b1001 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_res=8'h90, rsp_flags=4'b1001.
// - Contention: both valid continuously after reset -> grant order 0,1,0,1; rsp_id alternates accordingly.
// - Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req*_ready=0; accept resumes the cycle after the handshake.
// - Reset mid-EXEC: assert rst in EXEC -> no response ever issued for that command, all outputs 0, next req1 is granted first via req0-priority rules.
// - Sticky (ALU_STICKY_OVF_EN): req1 response with V=1 -> sticky_v=2'b10; sticky_clr=2'b10 on the same cycle as a new V=1 set -> stays 1; clear alone -> 0.

Source files
------------

// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and constants for the two-requester ALU sharing controller.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Bit positions inside the {N,Z,C,V} flag nibble
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef logic req_id_t;

    function automatic logic [1:0] id_onehot(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Bus bundle between the requesters/ALU/response consumer (master) and the
// sharing controller (slave).
interface alu_share_ctrl_if #(
    parameter int N   = 8,
    parameter int OPW = 4
);
    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op;
    logic [N-1:0]   req0_a;
    logic [N-1:0]   req0_b;
    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op;
    logic [N-1:0]   req1_a;
    logic [N-1:0]   req1_b;
    logic [OPW-1:0] alu_ctrl_o;
    logic [N-1:0]   alu_a_o;
    logic [N-1:0]   alu_b_o;
    logic [N-1:0]   alu_res_i;
    logic [3:0]     alu_flags_i;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [N-1:0]   rsp_res;
    logic [3:0]     rsp_flags;
    logic [1:0]     sticky_v;
    logic [1:0]     sticky_clr;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  alu_ctrl_o, alu_a_o, alu_b_o,
        output alu_res_i, alu_flags_i,
        input  rsp_valid, rsp_id, rsp_res, rsp_flags,
        output rsp_ready,
        input  sticky_v,
        output sticky_clr
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output alu_ctrl_o, alu_a_o, alu_b_o,
        input  alu_res_i, alu_flags_i,
        output rsp_valid, rsp_id, rsp_res, rsp_flags,
        input  rsp_ready,
        output sticky_v,
        input  sticky_clr
    );

endinterface

// File: rtl/alu_share_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie
// and moves to the other requester whenever a grant is taken.
module rr_arbiter2
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    req_id_t ptr_r;

    // Grant the sole requester, or the pointer's requester on contention
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = id_onehot(ptr_r);
        end else begin
            gnt = req;
        end
    end

    // Priority pointer: flips away from whoever was just served
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (advance) begin
            ptr_r <= ~gnt[1];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters: IDLE -> EXEC -> RESP.
// Optional per-requester sticky overflow under macro ALU_STICKY_OVF_EN.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int N   = 8,
    parameter int OPW = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_share_ctrl_if.slave   bus
);

    state_t         state_r;
    state_t         state_nxt_s;
    logic [1:0]     req_s;
    logic [1:0]     gnt_s;
    logic [1:0]     ready_s;
    logic           accept_s;
    req_id_t        gnt_id_s;

    logic [OPW-1:0] op_r;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    req_id_t        id_r;
    logic [N-1:0]   res_r;
    logic [3:0]     flags_r;
    req_id_t        rsp_id_r;

    assign req_s = {bus.req1_valid, bus.req0_valid};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_s),
        .advance (accept_s),
        .gnt     (gnt_s)
    );

    // Next state and per-requester ready; ready is only ever offered in IDLE
    always_comb begin
        state_nxt_s = state_r;
        ready_s     = 2'b00;
        case (state_r)
            IDLE: begin
                if (!rst && (gnt_s != 2'b00)) begin
                    ready_s     = gnt_s;
                    state_nxt_s = EXEC;
                end else begin
                    ready_s     = 2'b00;
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // A grant is only given to a valid requester, so ready alone marks the handshake
    assign accept_s = |ready_s;
    assign gnt_id_s = ready_s[1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command latch; also feeds the ALU and holds its value between commands
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r <= '0;
            a_r  <= '0;
            b_r  <= '0;
            id_r <= 1'b0;
        end else if (accept_s) begin
            op_r <= gnt_id_s ? bus.req1_op : bus.req0_op;
            a_r  <= gnt_id_s ? bus.req1_a  : bus.req0_a;
            b_r  <= gnt_id_s ? bus.req1_b  : bus.req0_b;
            id_r <= gnt_id_s;
        end else begin
            op_r <= op_r;
            a_r  <= a_r;
            b_r  <= b_r;
            id_r <= id_r;
        end
    end

    // Response capture at the end of the single EXEC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            res_r    <= '0;
            flags_r  <= 4'b0000;
            rsp_id_r <= 1'b0;
        end else if (state_r == EXEC) begin
            res_r    <= bus.alu_res_i;
            flags_r  <= bus.alu_flags_i;
            rsp_id_r <= id_r;
        end else begin
            res_r    <= res_r;
            flags_r  <= flags_r;
            rsp_id_r <= rsp_id_r;
        end
    end

    assign bus.req0_ready = ready_s[0];
    assign bus.req1_ready = ready_s[1];
    assign bus.alu_ctrl_o = op_r;
    assign bus.alu_a_o    = a_r;
    assign bus.alu_b_o    = b_r;
    assign bus.rsp_valid  = (state_r == RESP);
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_res    = res_r;
    assign bus.rsp_flags  = flags_r;

`ifdef ALU_STICKY_OVF_EN
    logic [1:0] sticky_r;
    logic [1:0] sticky_set_s;

    // Overflow seen on the edge that enters RESP, steered to the owning requester
    always_comb begin
        sticky_set_s = 2'b00;
        if ((state_r == EXEC) && bus.alu_flags_i[FLG_V]) begin
            sticky_set_s = id_onehot(id_r);
        end else begin
            sticky_set_s = 2'b00;
        end
    end

    // Sticky bits; a set in the same cycle overrides a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_r <= 2'b00;
        end else begin
            sticky_r <= sticky_set_s | (sticky_r & ~bus.sticky_clr);
        end
    end

    assign bus.sticky_v = sticky_r;
`else
    logic sticky_clr_unused_s;
    assign sticky_clr_unused_s = ^bus.sticky_clr;
    assign bus.sticky_v        = 2'b00;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios plus a randomized
// run scored against a transaction-level model of arbitration and latency.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [3:0] c_op [2];
    logic [7:0] c_a  [2];
    logic [7:0] c_b  [2];

    alu_share_ctrl_if #(.N(8), .OPW(4)) bus ();

    alu_share_ctrl #(.N(8), .OPW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference ALU: op[0]=subtract, op[2:1] selects arith/and/or/xor; returns {N,Z,C,V,res}
    function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       v;
        s = 9'd0;
        c = 1'b0;
        v = 1'b0;
        case (op[2:1])
            2'd0: begin
                if (op[0]) s = {1'b0, a} + {1'b0, ~b} + 9'd1;
                else       s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                if (op[0]) v = (a[7] != b[7]) && (r[7] != a[7]);
                else       v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            2'd1:    r = a & b;
            2'd2:    r = a | b;
            default: r = a ^ b;
        endcase
        return {r[7], (r == 8'd0), c, v, r};
    endfunction

    assign {bus.alu_flags_i, bus.alu_res_i} = alu_model(bus.alu_ctrl_o, bus.alu_a_o, bus.alu_b_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_op = 4'h0; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_op = 4'h0; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
        bus.rsp_ready  = 1'b1;
        bus.sticky_clr = 2'b00;
    endtask

    task automatic new_cmd(input int id);
        c_op[id] = 4'($urandom_range(15));
        c_a[id]  = 8'($urandom_range(255));
        c_b[id]  = 8'($urandom_range(255));
    endtask

    task automatic drive_cmds();
        bus.req0_op = c_op[0]; bus.req0_a = c_a[0]; bus.req0_b = c_b[0];
        bus.req1_op = c_op[1]; bus.req1_a = c_a[1]; bus.req1_b = c_b[1];
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b exp 00", {bus.req1_ready, bus.req0_ready});
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_flags} !== 14'd0) begin
            errors++; $display("FAIL reset_rsp got %h exp 0", {bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_flags});
        end
        checks++;
        if ({bus.alu_ctrl_o, bus.alu_a_o, bus.alu_b_o} !== 20'd0) begin
            errors++; $display("FAIL reset_alu got %h exp 0", {bus.alu_ctrl_o, bus.alu_a_o, bus.alu_b_o});
        end
        checks++;
        if (bus.sticky_v !== 2'b00) begin
            errors++; $display("FAIL reset_sticky got %b exp 00", bus.sticky_v);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_op = 4'h0; bus.req0_a = 8'h70; bus.req0_b = 8'h20;
        bus.rsp_ready  = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            errors++; $display("FAIL single_accept got %b exp 01", {bus.req1_ready, bus.req0_ready});
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_exec_valid got %b exp 0", bus.rsp_valid);
        end
        checks++;
        if ({bus.alu_ctrl_o, bus.alu_a_o, bus.alu_b_o} !== {4'h0, 8'h70, 8'h20}) begin
            errors++; $display("FAIL single_alu_drive got %h exp 07020", {bus.alu_ctrl_o, bus.alu_a_o, bus.alu_b_o});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_flags} !== {1'b1, 1'b0, 8'h90, 4'b1001}) begin
            errors++; $display("FAIL single_rsp got v=%b id=%b res=%h fl=%b exp v=1 id=0 res=90 fl=1001",
                               bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_flags);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.alu_a_o !== 8'h70) begin
            errors++; $display("FAIL single_after got v=%b a=%h exp v=0 a=70", bus.rsp_valid, bus.alu_a_o);
        end
    endtask

    task automatic test_contention();
        logic [12:0] exp_q[$];
        int          accepts;
        int          exp_id;
        int          refresh;
        reset_dut();
        new_cmd(0); new_cmd(1);
        drive_cmds();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        accepts = 0;
        exp_id  = 0;
        for (int cyc = 0; cyc < 40 && accepts < 6; cyc++) begin
            refresh = -1;
            @(negedge clk);
            if (bus.rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL contention_spurious_rsp id=%b exp none", bus.rsp_id);
                end else if ({bus.rsp_id, bus.rsp_flags, bus.rsp_res} !== exp_q[0]) begin
                    errors++; $display("FAIL contention_rsp got %h exp %h",
                                       {bus.rsp_id, bus.rsp_flags, bus.rsp_res}, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (bus.req0_ready || bus.req1_ready) begin
                checks++;
                if ({bus.req1_ready, bus.req0_ready} !== ((exp_id == 1) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL contention_grant got %b exp id %0d",
                                       {bus.req1_ready, bus.req0_ready}, exp_id);
                end
                exp_q.push_back({exp_id[0], alu_model(c_op[exp_id], c_a[exp_id], c_b[exp_id])});
                refresh = exp_id;
                exp_id  = 1 - exp_id;
                accepts++;
            end
            @(posedge clk); #1;
            if (refresh >= 0) begin
                new_cmd(refresh);
                drive_cmds();
            end
        end
        checks++;
        if (accepts != 6) begin
            errors++; $display("FAIL contention_timeout got %0d accepts exp 6", accepts);
        end
    endtask

    task automatic test_backpressure();
        logic [12:0] exp_rsp;
        reset_dut();
        new_cmd(0);
        c_op[1] = 4'h1; c_a[1] = 8'($urandom_range(255)); c_b[1] = 8'($urandom_range(255));
        drive_cmds();
        exp_rsp = {1'b1, alu_model(c_op[1], c_a[1], c_b[1])};
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            errors++; $display("FAIL bp_accept got %b exp 10", {bus.req1_ready, bus.req0_ready});
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req1_ready, bus.req0_ready, bus.rsp_valid} !== 3'b000) begin
            errors++; $display("FAIL bp_exec got rdy=%b v=%b exp 00/0", {bus.req1_ready, bus.req0_ready}, bus.rsp_valid);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 5) bus.rsp_ready = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid, bus.req1_ready, bus.req0_ready} !== 3'b100 ||
                {bus.rsp_id, bus.rsp_flags, bus.rsp_res} !== exp_rsp) begin
                errors++; $display("FAIL bp_stall%0d got v=%b rdy=%b rsp=%h exp v=1 rdy=00 rsp=%h", i,
                                   bus.rsp_valid, {bus.req1_ready, bus.req0_ready},
                                   {bus.rsp_id, bus.rsp_flags, bus.rsp_res}, exp_rsp);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.req1_ready, bus.req0_ready} !== 3'b001) begin
            errors++; $display("FAIL bp_resume got v=%b rdy=%b exp v=0 rdy=01",
                               bus.rsp_valid, {bus.req1_ready, bus.req0_ready});
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [12:0] exp_rsp;
        reset_dut();
        new_cmd(0); new_cmd(1);
        drive_cmds();
        exp_rsp = {1'b1, alu_model(c_op[1], c_a[1], c_b[1])};
        bus.req0_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            errors++; $display("FAIL rstmid_accept got %b exp 01", {bus.req1_ready, bus.req0_ready});
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req1_ready, bus.req0_ready, bus.rsp_valid} !== 3'b000) begin
            errors++; $display("FAIL rstmid_exec got rdy=%b v=%b exp 00/0", {bus.req1_ready, bus.req0_ready}, bus.rsp_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_flags, bus.alu_ctrl_o,
             bus.alu_a_o, bus.alu_b_o, bus.sticky_v} !== 36'd0) begin
            errors++; $display("FAIL rstmid_outputs got v=%b res=%h alu_a=%h exp all 0",
                               bus.rsp_valid, bus.rsp_res, bus.alu_a_o);
        end
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            errors++; $display("FAIL rstmid_req1_grant got %b exp 10", {bus.req1_ready, bus.req0_ready});
        end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_rsp got %b exp 0", bus.rsp_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_res} !== {1'b1, exp_rsp}) begin
            errors++; $display("FAIL rstmid_req1_rsp got v=%b rsp=%h exp v=1 rsp=%h",
                               bus.rsp_valid, {bus.rsp_id, bus.rsp_flags, bus.rsp_res}, exp_rsp);
        end
    endtask

    task automatic test_sticky();
        logic [1:0] exp_set;
`ifdef ALU_STICKY_OVF_EN
        exp_set = 2'b10;
`else
        exp_set = 2'b00;
`endif
        reset_dut();
        bus.req1_valid = 1'b1; bus.req1_op = 4'h0; bus.req1_a = 8'h70; bus.req1_b = 8'h20;
        @(negedge clk);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.sticky_v !== exp_set) begin
            errors++; $display("FAIL sticky_set got %b exp %b", bus.sticky_v, exp_set);
        end
        @(posedge clk); #1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        bus.sticky_clr = 2'b10;
        @(posedge clk); #1;
        bus.sticky_clr = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.sticky_v !== exp_set) begin
            errors++; $display("FAIL sticky_set_beats_clr got %b exp %b", bus.sticky_v, exp_set);
        end
        @(posedge clk); #1;
        bus.sticky_clr = 2'b10;
        @(posedge clk); #1;
        bus.sticky_clr = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.sticky_v !== 2'b00) begin
            errors++; $display("FAIL sticky_clear got %b exp 00", bus.sticky_v);
        end
    endtask

    task automatic test_random();
        bit          busy;
        bit          v0, v1, g0, g1;
        int          age;
        int          ptr_m;
        int          nrsp;
        int          id;
        logic [12:0] exp_rsp;
        reset_dut();
        busy = 1'b0; age = 0; ptr_m = 0; nrsp = 0; exp_rsp = 13'd0;
        new_cmd(0); new_cmd(1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            v0 = ($urandom_range(3) != 0);
            v1 = ($urandom_range(3) != 0);
            bus.req0_valid = v0;
            bus.req1_valid = v1;
            drive_cmds();
            bus.rsp_ready = ($urandom_range(2) != 0);
            @(negedge clk);
            g0 = !busy && v0 && (!v1 || ptr_m == 0);
            g1 = !busy && v1 && (!v0 || ptr_m == 1);
            checks++;
            if ({bus.req1_ready, bus.req0_ready} !== {g1, g0}) begin
                errors++; $display("FAIL rand_grant cyc %0d got %b exp %b", cyc,
                                   {bus.req1_ready, bus.req0_ready}, {g1, g0});
            end
            checks++;
            if (bus.rsp_valid !== (busy && age >= 2)) begin
                errors++; $display("FAIL rand_rsp_valid cyc %0d got %b exp %b", cyc,
                                   bus.rsp_valid, (busy && age >= 2));
            end
            if (busy && age >= 2) begin
                checks++;
                if ({bus.rsp_id, bus.rsp_flags, bus.rsp_res} !== exp_rsp) begin
                    errors++; $display("FAIL rand_rsp cyc %0d got %h exp %h", cyc,
                                       {bus.rsp_id, bus.rsp_flags, bus.rsp_res}, exp_rsp);
                end
            end
            if (busy) begin
                if (age >= 2 && bus.rsp_ready) begin
                    busy = 1'b0;
                    nrsp++;
                end else begin
                    age++;
                end
            end else if (g0 || g1) begin
                id      = g1 ? 1 : 0;
                exp_rsp = {id[0], alu_model(c_op[id], c_a[id], c_b[id])};
                busy    = 1'b1;
                age     = 1;
                ptr_m   = 1 - id;
                new_cmd(id);
            end
        end
        checks++;
        if (nrsp < 20) begin
            errors++; $display("FAIL rand_throughput got %0d responses exp >= 20", nrsp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid_exec();
        test_sticky();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
